// File: rtl/onchip_memory_init_bridge.sv
// Avalon-MM bridge in front of a 1-cycle single-port RAM: fills it with FILL_VALUE after reset/on clear_req.
// Pass-through adds 0 cycles, reads return 1 cycle after accept; host is stalled via s_waitrequest during fills.
module onchip_memory_init_bridge #(
    parameter int                ADDR_W         = 12,
    parameter int                DATA_W         = 32,
    parameter int                DEPTH          = 4096,
    parameter logic [DATA_W-1:0] FILL_VALUE     = '0,
    parameter int                CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     s_address,
    input  logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_read,
    input  logic                  s_write,
    input  logic [DATA_W-1:0]     s_writedata,
    output logic                  s_waitrequest,
    output logic [DATA_W-1:0]     s_readdata,
    output logic                  s_readdatavalid,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    output logic                  m_clken,
    input  logic [DATA_W-1:0]     m_readdata
);

    localparam int                BE_W      = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_fill_cnt;
    logic [ADDR_W-1:0]   w_fill_cnt_nxt;
    logic                r_rd_pend;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_acc_rd;
    logic                w_acc_wr;

    // clear_req stalls the host in its own cycle so no access races the fill start.
    assign s_waitrequest = (r_state != ST_IDLE) | clear_req | ~reset_n;
    assign w_acc_rd      = s_read  & ~s_waitrequest;
    assign w_acc_wr      = s_write & ~s_waitrequest;

    assign s_readdatavalid = r_rd_pend & reset_n;
    assign s_readdata      = s_readdatavalid ? m_readdata : '0;
    assign done            = r_done & reset_n;
    assign m_clken         = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= RESET_STATE;
            r_fill_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
            r_rd_pend  <= w_acc_rd & ~w_acc_wr;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        w_done_nxt     = 1'b0;
        busy           = 1'b0;
        m_address      = s_address;
        m_byteenable   = s_byteenable;
        m_writedata    = s_writedata;
        m_chipselect   = w_acc_rd | w_acc_wr;
        m_write        = w_acc_wr;

        case (r_state)
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy         = 1'b1;
                m_address    = r_fill_cnt;
                m_byteenable = {BE_W{1'b1}};
                m_writedata  = FILL_VALUE;
                m_chipselect = reset_n;
                m_write      = reset_n;
                if (r_fill_cnt == LAST_ADDR) begin
                    w_state_nxt    = ST_IDLE;
                    w_fill_cnt_nxt = '0;
                    w_done_nxt     = 1'b1;
                end else begin
                    w_fill_cnt_nxt = r_fill_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Reported busy tracks the state we are being reset into, not the stale one.
        if (!reset_n) begin
            busy = (CLEAR_ON_RESET != 0);
        end
    end

endmodule

// File: tb/tb_onchip_memory_init_bridge.sv
// Bench for onchip_memory_init_bridge: DEPTH=16 fill into a 32-word RAM model, directed vector table
// for pass-through/read pipelining, plus hand sequences for stalled fills, mid-fill reset and read-before-clear.
module tb_onchip_memory_init_bridge;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] s_address;
    logic [3:0]    s_byteenable;
    logic          s_read;
    logic          s_write;
    logic [31:0]   s_writedata;
    logic          s_waitrequest;
    logic [31:0]   s_readdata;
    logic          s_readdatavalid;
    logic          clear_req;
    logic          busy;
    logic          done;
    logic [AW-1:0] m_address;
    logic [3:0]    m_byteenable;
    logic          m_chipselect;
    logic          m_write;
    logic [31:0]   m_writedata;
    logic          m_clken;
    logic [31:0]   m_readdata;

    int total = 0;
    int bad   = 0;

    onchip_memory_init_bridge #(
        .ADDR_W(AW), .DATA_W(32), .DEPTH(16), .FILL_VALUE(32'h0), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .clear_req(clear_req), .busy(busy), .done(done),
        .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
        .m_write(m_write), .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata)
    );

    always #5 clk = ~clk;

    // RAM model: read-first, 1-cycle read latency, byte enables; preset to all ones so fills are visible.
    logic [31:0] mem [32];
    logic        ram_preset;
    always @(posedge clk) begin
        if (ram_preset) begin
            for (int k = 0; k < 32; k++) mem[k] <= 32'hFFFF_FFFF;
        end else if (m_clken && m_chipselect) begin
            m_readdata <= mem[m_address];
            if (m_write) begin
                for (int b = 0; b < 4; b++)
                    if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [4:0]  addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        ecs;
        logic        ewe;
        logic        ervld;
        logic [31:0] erd;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first fill cycle (just after the edge); leaves after checking the done cycle.
    task automatic run_fill(input string nm);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk({nm, "_addr"}, 64'(m_address), 64'(i));
            chk({nm, "_ctl"}, {busy, s_waitrequest, m_chipselect, m_write, done, s_readdatavalid, m_byteenable},
                {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF});
            chk({nm, "_wdata"}, 64'(m_writedata), 64'h0);
            tick();
        end
        #1;
        chk({nm, "_done"}, {done, busy, s_waitrequest, m_chipselect}, {1'b1, 1'b0, 1'b0, 1'b0});
    endtask

    int  fill_cyc;
    logic seen_done;

    initial begin
        vt[0]  = '{1'b0, 1'b1, 5'd5, 4'b0011, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 5'd5, 4'b1111, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 5'd0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000BEEF};
        vt[3]  = '{1'b0, 1'b1, 5'd1, 4'b1111, 32'd11,       1'b1, 1'b1, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 1'b1, 5'd2, 4'b1111, 32'd22,       1'b1, 1'b1, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 1'b1, 5'd3, 4'b1111, 32'd33,       1'b1, 1'b1, 1'b0, 32'h0};
        vt[6]  = '{1'b1, 1'b0, 5'd1, 4'b1111, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 5'd2, 4'b1111, 32'h0,        1'b1, 1'b0, 1'b1, 32'd11};
        vt[8]  = '{1'b1, 1'b0, 5'd3, 4'b1111, 32'h0,        1'b1, 1'b0, 1'b1, 32'd22};
        vt[9]  = '{1'b1, 1'b1, 5'd4, 4'b1111, 32'd44,       1'b1, 1'b1, 1'b1, 32'd33};
        vt[10] = '{1'b1, 1'b0, 5'd4, 4'b1111, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vt[11] = '{1'b0, 1'b0, 5'd0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 32'd44};
        vt[12] = '{1'b0, 1'b1, 5'd5, 4'b1100, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h0};
        vt[13] = '{1'b1, 1'b0, 5'd5, 4'b1111, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
        vt[14] = '{1'b0, 1'b0, 5'd0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b1, 32'h1234BEEF};
        vt[15] = '{1'b0, 1'b0, 5'd0, 4'b0000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};

        // Reset with host requests asserted: nothing may reach the RAM.
        reset_n = 1'b0; ram_preset = 1'b1; clear_req = 1'b0;
        s_read = 1'b1; s_write = 1'b1; s_address = 5'd9; s_byteenable = 4'hF; s_writedata = 32'h77;
        tick();
        #1;
        chk("rst_out", {busy, s_waitrequest, m_chipselect, m_write, s_readdatavalid, done, m_clken},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        tick();
        ram_preset = 1'b0; s_read = 1'b0; s_write = 1'b0;
        reset_n = 1'b1;
        run_fill("fill1");

        // IDLE pass-through and pipelined reads.
        for (int i = 0; i < 16; i++) begin
            tick();
            s_read = vt[i].rd; s_write = vt[i].wr; s_address = vt[i].addr;
            s_byteenable = vt[i].be; s_writedata = vt[i].wd;
            #1;
            chk("vec_ctl", {m_chipselect, m_write, s_waitrequest}, {vt[i].ecs, vt[i].ewe, 1'b0});
            chk("vec_pass", {m_address, m_byteenable, m_writedata}, {vt[i].addr, vt[i].be, vt[i].wd});
            chk("vec_rsp", {s_readdatavalid, s_readdata}, {vt[i].ervld, vt[i].erd});
        end

        // Write collides with clear_req: stalled across the whole fill, accepted on the done cycle.
        tick();
        s_read = 1'b0; s_write = 1'b1; s_address = 5'd2; s_byteenable = 4'hF; s_writedata = 32'h55;
        clear_req = 1'b1;
        #1;
        chk("t4_stall0", {s_waitrequest, m_chipselect, m_write}, {1'b1, 1'b0, 1'b0});
        tick();
        fill_cyc = 0; seen_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            clear_req = (n == 5);
            #1;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (busy) fill_cyc++;
            chk("t4_fill", {s_waitrequest, m_address}, {1'b1, 5'(n)});
            tick();
        end
        clear_req = 1'b0;
        chk("t4_done_seen", 64'(seen_done), 64'd1);
        chk("t4_fill_len", 64'(fill_cyc), 64'd16);
        chk("t4_acc", {s_waitrequest, m_chipselect, m_write, m_address, m_writedata},
            {1'b0, 1'b1, 1'b1, 5'd2, 32'h55});
        tick();
        s_write = 1'b0; s_read = 1'b1;
        #1;
        chk("t4_rd", {m_chipselect, m_write, m_address}, {1'b1, 1'b0, 5'd2});
        tick();
        s_read = 1'b0;
        #1;
        chk("t4_rsp", {s_readdatavalid, s_readdata}, {1'b1, 32'h55});

        // Read accepted just before clear_req: response still returns the pre-fill data.
        tick();
        s_write = 1'b1; s_address = 5'd3; s_writedata = 32'h333;
        tick();
        s_write = 1'b0; s_read = 1'b1;
        #1;
        chk("t6_acc", {m_chipselect, m_write, s_waitrequest}, {1'b1, 1'b0, 1'b0});
        tick();
        s_read = 1'b0; clear_req = 1'b1;
        #1;
        chk("t6_rsp", {s_readdatavalid, s_readdata, s_waitrequest}, {1'b1, 32'h333, 1'b1});
        tick();
        clear_req = 1'b0;
        #1;
        chk("t6_after", {s_readdatavalid, busy, m_address}, {1'b0, 1'b1, 5'd0});

        // Reset pulse at fill_cnt=7 restarts the fill from address 0.
        for (int i = 1; i <= 7; i++) tick();
        #1;
        chk("t5_cnt7", 64'(m_address), 64'd7);
        reset_n = 1'b0;
        #1;
        chk("t5_rst", {busy, s_waitrequest, m_chipselect, m_write, s_readdatavalid, done},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tick();
        reset_n = 1'b1;
        run_fill("fill2");

        tick();
        for (int i = 0; i < 32; i++)
            chk("ram_final", 64'(mem[i]), (i < 16) ? 64'h0 : 64'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
